// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator pair evaluator.
package ro_puf_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_WIN_W   = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    COUNT   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Selects one oscillator of a group, synchronises it to clk and counts its
// rising edges with a saturating counter.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int unsigned N_RO  = 8,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_RO-1:0]         ro,
  input  logic [$clog2(N_RO)-1:0] sel,
  input  logic                    clr,
  input  logic                    en,
  output logic [CNT_W-1:0]        count,
  output logic                    sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                   ro_sel;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;

  always_comb begin
    ro_sel = ro[sel];
    rise   = sync[SYNC_STAGES-1] & ~prev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro_sel};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // sat marks the counter having reached full scale, not only an overflow attempt
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (en && rise) begin
      if (count != CNT_MAX) count <= count + CNT_W'(1);
      if (count >= CNT_MAX - CNT_W'(1)) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/ro_puf_pair_eval.sv
// Challenge-selected RO pair evaluation: settle, count over a window,
// compare and hold the response bit with the raw counts.
module ro_puf_pair_eval
  import ro_puf_pkg::*;
#(
  parameter int unsigned N_RO       = 8,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned WIN_W      = DEF_WIN_W,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [$clog2(N_RO)-1:0] sel_a,
  input  logic [$clog2(N_RO)-1:0] sel_b,
  input  logic [WIN_W-1:0]        window_len,
  input  logic [N_RO-1:0]         ro_a,
  input  logic [N_RO-1:0]         ro_b,
  output logic                    ro_en,
  output logic                    busy,
  output logic                    done,
  output logic                    response,
  output logic                    tie,
  output logic                    sat,
  output logic [CNT_W-1:0]        count_a,
  output logic [CNT_W-1:0]        count_b
);

  localparam int unsigned SEL_W = $clog2(N_RO);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);

  state_t           state;
  logic [SEL_W-1:0] sel_a_q;
  logic [SEL_W-1:0] sel_b_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] tmr;
  logic             accept;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             sat_a;
  logic             sat_b;

  always_comb begin
    accept = (state == IDLE) && start;
    cnt_en = (state == COUNT);
    ro_en  = (state == SETTLE) || (state == COUNT);
    busy   = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmr     <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      win_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_a_q <= sel_a;
            sel_b_q <= sel_b;
            win_q   <= window_len;
            tmr     <= '0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr == SETTLE_LAST) begin
            tmr   <= '0;
            state <= (win_q == '0) ? COMPARE : COUNT;
          end else begin
            tmr <= tmr + WIN_W'(1);
          end
        end
        COUNT: begin
          if (tmr == win_q - WIN_W'(1)) state <= COMPARE;
          else                          tmr   <= tmr + WIN_W'(1);
        end
        COMPARE: state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ro_edge_counter #(.N_RO(N_RO), .CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .ro    (ro_a),
    .sel   (sel_a_q),
    .clr   (accept),
    .en    (cnt_en),
    .count (cnt_a),
    .sat   (sat_a)
  );

  ro_edge_counter #(.N_RO(N_RO), .CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .ro    (ro_b),
    .sel   (sel_b_q),
    .clr   (accept),
    .en    (cnt_en),
    .count (cnt_b),
    .sat   (sat_b)
  );

  // done is registered off DONE so it lands the cycle the FSM is back in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      response <= 1'b0;
      tie      <= 1'b0;
      sat      <= 1'b0;
      count_a  <= '0;
      count_b  <= '0;
    end else begin
      done <= (state == DONE);
      if (accept) begin
        response <= 1'b0;
        tie      <= 1'b0;
        sat      <= 1'b0;
        count_a  <= '0;
        count_b  <= '0;
      end else if (state == COMPARE) begin
        response <= (cnt_a > cnt_b);
        tie      <= (cnt_a == cnt_b);
        sat      <= sat_a | sat_b;
        count_a  <= cnt_a;
        count_b  <= cnt_b;
      end
    end
  end

endmodule

// File: tb/tb_ro_puf_pair_eval.sv
// Bench for ro_puf_pair_eval: modelled oscillators, a timeline/result model
// and a per-cycle compare of a 16-bit and a 4-bit counter instance.
`timescale 1ns/1ps
module tb_ro_puf_pair_eval;

  localparam int N  = 8;
  localparam int SW = 3;
  localparam int S  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] sel_a = '0;
  logic [SW-1:0] sel_b = '0;
  logic [15:0]   window_len = '0;
  logic [N-1:0]  ro_a = '0;
  logic [N-1:0]  ro_b = '0;

  logic        ro_en, busy, done, response, tie, sat;
  logic [15:0] count_a, count_b;
  logic        ro_en4, busy4, done4, response4, tie4, sat4;
  logic [3:0]  count_a4, count_b4;

  ro_puf_pair_eval #(.N_RO(8), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b),
    .window_len(window_len), .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en),
    .busy(busy), .done(done), .response(response), .tie(tie), .sat(sat),
    .count_a(count_a), .count_b(count_b)
  );

  ro_puf_pair_eval #(.N_RO(8), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b),
    .window_len(window_len), .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en4),
    .busy(busy4), .done(done4), .response(response4), .tie(tie4), .sat(sat4),
    .count_a(count_a4), .count_b(count_b4)
  );

  always #5 clk = ~clk;

  // Oscillator i of a group has a period of per[i] clk cycles; edges sit 3 ns before posedges.
  int per_a[N], per_b[N], ph_a[N], ph_b[N];

  function automatic logic osc(input longint t, input int per, input int ph);
    if (t < longint'(ph)) return 1'b0;
    return (((t - longint'(ph)) / longint'(5 * per)) % 2) == 1;
  endfunction

  always begin
    #1;
    for (int i = 0; i < N; i++) begin
      ro_a[i] = osc(longint'($time), per_a[i], ph_a[i]);
      ro_b[i] = osc(longint'($time), per_b[i], ph_b[i]);
    end
  end

  typedef struct {
    logic resp;
    logic tie;
    logic sat;
    int   ca;
    int   cb;
  } res_t;

  function automatic res_t res_zero();
    res_t r;
    r.resp = 1'b0; r.tie = 1'b0; r.sat = 1'b0; r.ca = 0; r.cb = 0;
    return r;
  endfunction

  function automatic res_t mk(input int ea, input int eb, input int w);
    res_t r;
    int   mx;
    mx    = (1 << w) - 1;
    r.ca  = (ea > mx) ? mx : ea;
    r.cb  = (eb > mx) ? mx : eb;
    r.sat = (ea >= mx) || (eb >= mx);
    r.resp = r.ca > r.cb;
    r.tie  = r.ca == r.cb;
    return r;
  endfunction

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   chk_en = 0;
  bit   active = 0;
  int   k, L, ea, eb;
  logic m_ro_en = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  res_t m16, m4, p16, p4;

  // Timeline model: a run accepted at edge e occupies S+W cycles of enable,
  // then compare, result registered at e+S+W+1, done after edge e+S+W+2.
  initial begin
    m16 = res_zero(); m4 = res_zero(); p16 = res_zero(); p4 = res_zero();
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      m_done = 1'b0;
      if (rst) begin
        active = 0; m_ro_en = 1'b0; m_busy = 1'b0;
        m16 = res_zero(); m4 = res_zero();
      end else if (!active) begin
        if (start) begin
          active = 1; k = 0; L = S + int'(window_len);
          ea  = int'(window_len) / per_a[int'(sel_a)];
          eb  = int'(window_len) / per_b[int'(sel_b)];
          p16 = mk(ea, eb, 16);
          p4  = mk(ea, eb, 4);
          m16 = res_zero(); m4 = res_zero();
          m_ro_en = 1'b1; m_busy = 1'b1;
        end
      end else begin
        k = k + 1;
        m_ro_en = (k < L);
        if (k == L + 1) begin m16 = p16; m4 = p4; end
        if (k == L + 2) begin m_done = 1'b1; m_busy = 1'b0; active = 0; end
      end
    end
  end

  task automatic check_one(input string nm, input logic e, input logic b, input logic d,
                           input logic r, input logic t, input logic s,
                           input logic [31:0] ca, input logic [31:0] cb, input res_t x);
    n_checks++;
    if (e !== m_ro_en || b !== m_busy || d !== m_done || r !== x.resp || t !== x.tie ||
        s !== x.sat || ca !== 32'(x.ca) || cb !== 32'(x.cb)) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got en=%b busy=%b done=%b resp=%b tie=%b sat=%b ca=%0d cb=%0d want en=%b busy=%b done=%b resp=%b tie=%b sat=%b ca=%0d cb=%0d",
               nm, cyc, e, b, d, r, t, s, ca, cb, m_ro_en, m_busy, m_done,
               x.resp, x.tie, x.sat, x.ca, x.cb);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      check_one("dut16", ro_en, busy, done, response, tie, sat,
                {16'b0, count_a}, {16'b0, count_b}, m16);
      check_one("dut4", ro_en4, busy4, done4, response4, tie4, sat4,
                {28'b0, count_a4}, {28'b0, count_b4}, m4);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int pick_per();
    case ($urandom_range(0, 4))
      0:       return 4;
      1:       return 6;
      2:       return 8;
      3:       return 10;
      default: return 12;
    endcase
  endfunction

  task automatic set_periods();
    for (int i = 0; i < N; i++) begin
      per_a[i] = pick_per();
      per_b[i] = pick_per();
      ph_a[i]  = 2 + 10 * int'($urandom_range(0, per_a[i] - 1));
      ph_b[i]  = 2 + 10 * int'($urandom_range(0, per_b[i] - 1));
    end
  endtask

  function automatic int lcm(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return (a / x) * b;
  endfunction

  task automatic wait_done(input int x, output int lat);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = cyc - x; break; end
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done within 3000 cycles want done");
    end
    tick();
  endtask

  task automatic run(input int sa, input int sb, input int w, output int lat);
    int x;
    x = cyc;
    sel_a = SW'(sa); sel_b = SW'(sb); window_len = 16'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(x, lat);
  endtask

  initial begin
    int lat, x, dc0, sa, sb, w, l;
    set_periods();
    tick();
    chk_en = 1;
    repeat (2) tick();
    chk("rst_ro_en", int'(ro_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_tie", int'(tie), 0);
    rst = 1'b0;
    tick();

    // A faster than B: periods 6 and 10 over 600 cycles
    per_a[3] = 6; ph_a[3] = 2; per_b[5] = 10; ph_b[5] = 12;
    run(3, 5, 600, lat);
    chk("latA", lat, S + 603);
    chk("caA", int'(count_a), 100);
    chk("cbA", int'(count_b), 60);
    chk("respA", int'(response), 1);
    chk("tieA", int'(tie), 0);
    chk("satA", int'(sat), 0);
    chk("tie4A", int'(tie4), 1);

    // swapped frequencies
    per_a[3] = 10; per_b[5] = 6;
    run(3, 5, 600, lat);
    chk("caB", int'(count_a), 60);
    chk("cbB", int'(count_b), 100);
    chk("respB", int'(response), 0);
    chk("tieB", int'(tie), 0);

    // identical, phase-aligned
    per_a[3] = 8; ph_a[3] = 32; per_b[5] = 8; ph_b[5] = 32;
    run(3, 5, 400, lat);
    chk("caC", int'(count_a), 50);
    chk("cbC", int'(count_b), 50);
    chk("tieC", int'(tie), 1);
    chk("respC", int'(response), 0);

    // 4-bit counter saturation, compare still meaningful
    per_a[3] = 4; per_b[5] = 20; ph_b[5] = 72;
    run(3, 5, 200, lat);
    chk("ca4D", int'(count_a4), 15);
    chk("cb4D", int'(count_b4), 10);
    chk("sat4D", int'(sat4), 1);
    chk("resp4D", int'(response4), 1);
    chk("sat16D", int'(sat), 0);

    // zero window, with a second start while busy
    dc0 = done_cnt;
    x = cyc;
    sel_a = 3'd1; sel_b = 3'd1; window_len = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    sel_a = 3'd7; window_len = 16'd100;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(x, lat);
    chk("latE", lat, S + 3);
    chk("caE", int'(count_a), 0);
    chk("tieE", int'(tie), 1);
    repeat (150) tick();
    chk("doneOnceE", done_cnt - dc0, 1);

    // reset during COUNT
    per_a[3] = 6; ph_a[3] = 2; per_b[5] = 10; ph_b[5] = 12;
    sel_a = 3'd3; sel_b = 3'd5; window_len = 16'd600;
    start = 1'b1; tick(); start = 1'b0;
    repeat (S + 50) tick();
    rst = 1'b1; tick();
    chk("rstF_ro_en", int'(ro_en), 0);
    chk("rstF_busy", int'(busy), 0);
    chk("rstF_ca", int'(count_a), 0);
    chk("rstF_cb", int'(count_b), 0);
    rst = 1'b0;
    dc0 = done_cnt;
    repeat (700) tick();
    chk("noDoneF", done_cnt - dc0, 0);
    run(3, 5, 600, lat);
    chk("latF2", lat, S + 603);
    chk("caF2", int'(count_a), 100);
    chk("respF2", int'(response), 1);

    // randomized challenges and oscillator banks
    for (int t = 0; t < 15; t++) begin
      set_periods();
      sa = int'($urandom_range(0, N - 1));
      sb = int'($urandom_range(0, N - 1));
      l  = lcm(per_a[sa], per_b[sb]);
      w  = l * int'($urandom_range(0, 600 / l));
      repeat (4) tick();
      x = cyc;
      sel_a = SW'(sa); sel_b = SW'(sb); window_len = 16'(w);
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      sel_a = SW'($urandom_range(0, N - 1));
      sel_b = SW'($urandom_range(0, N - 1));
      window_len = 16'($urandom_range(0, 65535));
      start = 1'b1; tick(); start = 1'b0;
      wait_done(x, lat);
      chk("latR", lat, S + w + 3);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ro_puf_pair_eval.md
Name: ro_puf_pair_eval

Overview:
- Parametrised successor to the fixed 2x8 ring-oscillator bank.
- Takes two groups of N_RO free-running oscillator outputs and selects one oscillator per group from a challenge.
- Counts rising edges of both selected oscillators over a programmable clock-cycle window, then emits one PUF response bit (A faster than B) plus the raw counts.
- Sits between the keep-protected RO bank (which it enables via ro_en) and the response-collection / readout logic.

Parameters:
- N_RO, 8, oscillators per group (A and B); power of two, >=2
- SEL_W, $clog2(N_RO), challenge select width per group (derived; not overridden)
- CNT_W, 16, edge-counter width
- WIN_W, 16, window-length width
- SETTLE_CYC, 16, cycles ro_en is held before counting starts (oscillator start-up)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- sel_a  in  SEL_W  oscillator index in group A; latched on accepted start
- sel_b  in  SEL_W  oscillator index in group B; latched on accepted start
- window_len  in  WIN_W  count window in clk cycles; latched on accepted start
- ro_a  in  N_RO  raw oscillator outputs, group A (asynchronous to clk)
- ro_b  in  N_RO  raw oscillator outputs, group B (asynchronous to clk)
- ro_en  out  1  oscillator enable to the RO bank
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; result valid
- response  out  1  1 when count_a > count_b; held until the next accepted start
- tie  out  1  count_a == count_b; held with response
- sat  out  1  either counter saturated during the window; held with response
- count_a  out  CNT_W  final edge count, group A; held
- count_b  out  CNT_W  final edge count, group B; held

Behaviour:
- Reset:
  - FSM enters IDLE.
  - ro_en, busy, done, response, tie and sat are all 0.
  - count_a and count_b are 0.
  - Synchroniser flops are cleared.
- FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
  - IDLE: start=1 latches sel_a, sel_b and window_len; clears counters and sat; moves to SETTLE. busy goes high the next cycle.
  - SETTLE: ro_en=1. Stays SETTLE_CYC cycles, then moves to COUNT. If latched window_len==0, moves directly to COMPARE instead.
  - COUNT: ro_en=1; both counters are enabled. Stays exactly window_len cycles, then moves to COMPARE.
  - COMPARE: ro_en=0 and counting stops. Registers response = (cnt_a > cnt_b), tie = (cnt_a == cnt_b), the final counts, and sat. Moves to DONE.
  - DONE: done=1 for one cycle, busy=0, then returns to IDLE.
- Latency from start to done = SETTLE_CYC + window_len + 3 cycles.
  - Example with defaults and window_len=100: start at cycle 0, done at cycle 119.
- Edge counting:
  - The selected oscillator (mux by the latched index) passes through a 2-flop synchroniser and a third flop for edge detect.
  - A rising edge is old=0, new=1. It increments the counter only while in COUNT.
  - Edges still in the synchroniser pipeline when COUNT ends are discarded.
  - Oscillator frequency must be < clk/2 for exact counts. Faster oscillators alias; this is documented, not detected.
- Saturation: counters stick at 2^CNT_W-1 and set sat. The comparison uses the saturated values.
- start while busy is ignored: no queueing, and latched inputs are unchanged.
- Changing sel_a, sel_b or window_len while busy has no effect.
- rst mid-operation: returns to IDLE within one cycle, ro_en drops, outputs go to reset values, and no done is issued.
- sel_a == sel_b is legal, because the indices address different groups.

Decomposition:
- Package ro_puf_pkg holds:
  - the FSM state enum (IDLE, SETTLE, COUNT, COMPARE, DONE);
  - localparam SYNC_STAGES = 2;
  - the default CNT_W and WIN_W constants.
- Sub-module ro_edge_counter (params N_RO, CNT_W), instantiated once per group. It contains:
  - the index mux;
  - the synchroniser and edge detect;
  - the saturating counter with clear/enable;
  - the sat flag.
- The top level holds the FSM, window/settle counter, compare and output registers.

Test Plan:
- Bench RO model with A[3] period 6 clk and B[5] period 10 clk. sel_a=3, sel_b=5, window_len=600 -> done at cycle SETTLE_CYC+603; count_a=100+/-1, count_b=60+/-1; response=1, tie=0, sat=0.
- Swap frequencies (A[3] period 10, B[5] period 6), same challenge -> response=0, tie=0.
- Identical periods of 8, phase-aligned, window_len=400 -> count_a=count_b=50, tie=1, response=0.
- CNT_W=4, A period 4, window_len=200 -> count_a=15, sat=1; compare still valid.
- window_len=0 -> done at SETTLE_CYC+3; counts 0, tie=1. Also: a second start while busy is ignored, and done pulses exactly once.
- rst asserted in COUNT -> next cycle ro_en=0, busy=0, counts 0, and no done pulse. A fresh start then completes normally.
